// File: rtl/i2c_pkg.sv
// Shared types for the I2C EEPROM target: byte-level FSM states and ACK bit levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV_ADDR = 4'd1,
    ACK_DEV  = 4'd2,
    ADDR_HI  = 4'd3,
    ACK_HI   = 4'd4,
    ADDR_LO  = 4'd5,
    ACK_LO   = 4'd6,
    WR_DATA  = 4'd7,
    ACK_WR   = 4'd8,
    RD_DATA  = 4'd9,
    MACK     = 4'd10
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA and flags SCL edges and START/STOP, 3 clk after the pin edge.
// SDA moving in the same sample as SCL is treated as data, never as START/STOP.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  // [0],[1] form the synchronizer, [2] is the history flop
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       rise_q, fall_q, start_q, stop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q   <= '1;
      sda_q   <= '1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      scl_q   <= {scl_q[1:0], scl_i};
      sda_q   <= {sda_q[1:0], sda_i};
      rise_q  <= scl_q[1] & ~scl_q[2];
      fall_q  <= ~scl_q[1] & scl_q[2];
      start_q <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_q  <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end

  // History flop lines up with the registered pulses
  assign sda_o       = sda_q[2];
  assign scl_rise_o  = rise_q;
  assign scl_fall_o  = fall_q;
  assign start_det_o = start_q;
  assign stop_det_o  = stop_q;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 24LC32A-style EEPROM in on-chip registers (AWIDTH between 9 and 16).
// Page-wrapped writes, sequential reads with full-array wrap; SDA driven open-drain through sda_oe.
module i2c_eeprom_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR  = 7'h50,
  parameter int         AWIDTH    = 10,
  parameter int         PAGE_BITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_stb,
  output logic [AWIDTH-1:0] wr_addr
);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [6:0]          shift_q, shift_d;
  logic [6:0]          tx_q, tx_d;
  logic [AWIDTH-9:0]   hi_q, hi_d;
  logic [AWIDTH-1:0]   ptr_q, ptr_d;
  logic                rw_q, rw_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                wr_stb_q, wr_stb_d;
  logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                mem_we, load_rd;
  logic [7:0]          mem [2**AWIDTH];

  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, rd_byte;
  logic       byte_done;

  i2c_bus_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .sda_o       (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  assign rx_byte   = {shift_q, sda_s};
  assign rd_byte   = mem[ptr_q];
  assign byte_done = scl_rise && (cnt_q == 4'd7);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    hi_d      = hi_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    mem_we    = 1'b0;
    load_rd   = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = DEV_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      if (scl_rise && (state_q inside {DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA})) begin
        shift_d = rx_byte[6:0];
        cnt_d   = cnt_q + 4'd1;
      end
      case (state_q)
        DEV_ADDR: if (byte_done) begin
          rw_d    = rx_byte[0];
          state_d = (rx_byte[7:1] == SLV_ADDR) ? ACK_DEV : IDLE;
        end
        ADDR_HI: if (byte_done) begin
          hi_d    = rx_byte[AWIDTH-9:0];
          state_d = ACK_HI;
        end
        ADDR_LO: if (byte_done) begin
          ptr_d   = {hi_q, rx_byte};
          state_d = ACK_LO;
        end
        WR_DATA: if (byte_done) begin
          mem_we    = 1'b1;
          wr_stb_d  = 1'b1;
          wr_addr_d = ptr_q;
          ptr_d     = {ptr_q[AWIDTH-1:PAGE_BITS], ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};
          state_d   = ACK_WR;
        end
        // First SCL fall drives the ACK, the second one releases it
        ACK_DEV, ACK_HI, ACK_LO, ACK_WR: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = ~ACK;
            if (state_q == ACK_DEV) busy_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            case (state_q)
              ACK_DEV: if (rw_q) load_rd = 1'b1;
                       else      state_d = ADDR_HI;
              ACK_HI:  state_d = ADDR_LO;
              default: state_d = WR_DATA;
            endcase
          end
        end
        RD_DATA: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            state_d  = MACK;
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = ~tx_q[6];
            tx_d     = {tx_q[5:0], 1'b0};
            cnt_d    = cnt_q + 4'd1;
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) state_d = IDLE;
            else               ptr_d   = ptr_q + AWIDTH'(1);
          end else if (scl_fall) begin
            load_rd = 1'b1;
          end
        end
        default: ;
      endcase
      if (load_rd) begin
        state_d  = RD_DATA;
        sda_oe_d = ~rd_byte[7];
        tx_d     = rd_byte[6:0];
        cnt_d    = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      hi_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      hi_q      <= hi_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr_q] <= rx_byte;
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bit-banged I2C master driving the EEPROM target, checked against an array model of the EEPROM.
module tb_i2c_eeprom_slave;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int PAGE  = 32;
  localparam int Q     = 6;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_oe, busy, wr_stb;
  logic [AW-1:0] wr_addr;
  wire           sda_line;

  assign sda_line = sda_m & ~sda_oe;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] mmem [DEPTH];
  bit         mval [DEPTH];
  int         wr_log[$];
  int         exp_wr[$];
  logic [7:0] tx_data[$];
  logic [7:0] rd_buf[$];

  always #5 clk = ~clk;

  i2c_eeprom_slave #(.SLV_ADDR(7'h50), .AWIDTH(AW), .PAGE_BITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr)
  );

  always @(negedge clk) if (!rst && wr_stb === 1'b1) wr_log.push_back(int'(wr_addr));

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: bench still running after 90000 cycles, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_q;
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; wait_q; scl_m = 1'b1; wait_q; sda_m = 1'b0; wait_q; scl_m = 1'b0; wait_q;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wait_q; scl_m = 1'b1; wait_q; sda_m = 1'b1; wait_q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q; scl_m = 1'b1; wait_q; wait_q; scl_m = 1'b0; wait_q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q; scl_m = 1'b1; wait_q; b = sda_line; wait_q; scl_m = 1'b0; wait_q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic v;
    b = '0;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    write_bit(mack);
  endtask

  // START, device write address, word address (random junk in the unused high bits), tx_data
  task automatic xfer_write(input int addr, input bit do_stop, output int nacks);
    logic       a;
    logic [7:0] hi;
    nacks = 0;
    hi = {6'($urandom_range(0, 63)), 2'(addr >> 8)};
    bus_start;
    write_byte(8'hA0, a);       if (a !== 1'b0) nacks++;
    write_byte(hi, a);          if (a !== 1'b0) nacks++;
    write_byte(8'(addr), a);    if (a !== 1'b0) nacks++;
    foreach (tx_data[i]) begin
      write_byte(tx_data[i], a);
      if (a !== 1'b0) nacks++;
    end
    if (do_stop) bus_stop;
  endtask

  // Random read of n bytes: address phase, repeated START, ACK all but the last byte
  task automatic xfer_read(input int addr, input int n, output int nacks);
    logic       a;
    logic [7:0] b;
    tx_data.delete();
    xfer_write(addr, 1'b0, nacks);
    bus_start;
    write_byte(8'hA1, a);
    if (a !== 1'b0) nacks++;
    rd_buf.delete();
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? 1'b1 : 1'b0, b);
      rd_buf.push_back(b);
    end
    bus_stop;
  endtask

  // Page write: each byte lands at page base + (offset + i) mod page size
  task automatic model_write(input int addr);
    int base, off, a;
    base = addr - (addr % PAGE);
    off  = addr % PAGE;
    exp_wr.delete();
    foreach (tx_data[i]) begin
      a = base + ((off + i) % PAGE);
      mmem[a] = tx_data[i];
      mval[a] = 1'b1;
      exp_wr.push_back(a);
    end
  endtask

  function automatic bit logs_match();
    if (wr_log.size() != exp_wr.size()) return 1'b0;
    foreach (wr_log[i]) if (wr_log[i] != exp_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (wr_stb !== 1'b0) begin miscompares++; $display("FAIL reset_wr_stb got=%b exp=0", wr_stb); end
    vectors++; if (wr_addr !== '0) begin miscompares++; $display("FAIL reset_wr_addr got=%h exp=000", wr_addr); end
    rst = 1'b0;
    wait_q;
  endtask

  task automatic test_write;
    int n;
    wr_log.delete();
    tx_data.delete(); tx_data.push_back(8'hA5);
    xfer_write(12'h012, 1'b0, n);
    model_write(12'h012);
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL write_acks nacks=%0d exp=0", n); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy_held got=%b exp=1", busy); end
    bus_stop; wait_q;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
    vectors++;
    if (wr_log.size() != 1 || wr_log[0] != 32'h012) begin
      miscompares++;
      $display("FAIL write_wr_stb pulses=%0d first=%h exp pulses=1 addr=012",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : -1);
    end
  endtask

  task automatic test_random_read;
    int n;
    xfer_read(12'h012, 1, n);
    wait_q;
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL rread_acks nacks=%0d exp=0", n); end
    vectors++; if (rd_buf[0] !== mmem[12'h012]) begin miscompares++; $display("FAIL rread_data got=%h exp=%h", rd_buf[0], mmem[12'h012]); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rread_busy got=%b exp=0", busy); end
  endtask

  task automatic test_page_wrap;
    int n, m;
    tx_data.delete(); tx_data.push_back(8'($urandom));
    xfer_write(10'h3FF, 1'b1, n);
    model_write(10'h3FF);
    wr_log.delete();
    tx_data.delete(); tx_data.push_back(8'h01); tx_data.push_back(8'h02); tx_data.push_back(8'h03);
    xfer_write(10'h01F, 1'b1, m);
    model_write(10'h01F);
    vectors++; if (n + m !== 0) begin miscompares++; $display("FAIL page_acks nacks=%0d exp=0", n + m); end
    vectors++;
    if (!logs_match()) begin
      miscompares++;
      $display("FAIL page_wr_addrs pulses=%0d first=%h exp pulses=%0d first=%h",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : -1, exp_wr.size(), exp_wr[0]);
    end
    xfer_read(10'h3FF, 3, n);
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL page_read_acks nacks=%0d exp=0", n); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rd_buf[i] !== mmem[(10'h3FF + i) % DEPTH]) begin
        miscompares++;
        $display("FAIL page_seq_read[%0d] got=%h exp=%h", i, rd_buf[i], mmem[(10'h3FF + i) % DEPTH]);
      end
    end
  endtask

  task automatic test_wrong_addr;
    logic a, a2, a3;
    wr_log.delete();
    bus_start;
    write_byte(8'hA2, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL wrong_addr_ack got=%b exp=1", a); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wrong_addr_busy got=%b exp=0", busy); end
    write_byte(8'h00, a2);
    write_byte(8'h55, a3);
    bus_stop; wait_q;
    vectors++;
    if (wr_log.size() != 0 || a2 !== 1'b1 || a3 !== 1'b1) begin
      miscompares++;
      $display("FAIL wrong_addr_ignored pulses=%0d acks=%b%b exp pulses=0 acks=11", wr_log.size(), a2, a3);
    end
  endtask

  task automatic test_partial;
    int         addr, n;
    logic       a, a1, a2, a3;
    logic [7:0] b;
    addr = $urandom_range(0, DEPTH - 1);
    tx_data.delete(); tx_data.push_back(8'($urandom));
    xfer_write(addr, 1'b1, n);
    model_write(addr);
    wr_log.delete();
    bus_start;
    write_byte(8'hA0, a1);
    write_byte(8'(addr >> 8), a2);
    write_byte(8'(addr), a3);
    for (int i = 0; i < 4; i++) write_bit(1'($urandom));
    bus_stop; wait_q;
    vectors++;
    if (wr_log.size() != 0 || busy !== 1'b0 || sda_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL partial_abort pulses=%0d busy=%b sda_oe=%b exp 0/0/0", wr_log.size(), busy, sda_oe);
    end
    // current-address read: the aborted byte must leave both memory and pointer intact
    bus_start;
    write_byte(8'hA1, a);
    read_byte(1'b1, b);
    bus_stop;
    vectors++;
    if ({n[0], a1, a2, a3, a} !== 5'b0 || b !== mmem[addr]) begin
      miscompares++;
      $display("FAIL partial_readback got=%h acks=%b%b%b%b exp=%h acks=0000", b, a1, a2, a3, a, mmem[addr]);
    end
  endtask

  task automatic test_reset_mid_read;
    int         addr, n;
    logic       a;
    logic [7:0] hi;
    tx_data.delete(); tx_data.push_back(8'h3C);
    xfer_write(10'h2A0, 1'b1, n);
    model_write(10'h2A0);
    hi = 8'h02;
    bus_start;
    write_byte(8'hA0, a); write_byte(hi, a); write_byte(8'hA0, a);
    bus_start;
    write_byte(8'hA1, a);
    vectors++; if (sda_oe !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL midread_driving sda_oe=%b busy=%b exp 1/1", sda_oe, busy); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL midread_rst_sda_oe got=%b exp=0", sda_oe); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midread_rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    wait_q;
    bus_stop;
    addr = $urandom_range(0, DEPTH - 1);
    tx_data.delete(); tx_data.push_back(8'($urandom)); tx_data.push_back(8'($urandom));
    xfer_write(addr, 1'b1, n);
    model_write(addr);
    xfer_read(exp_wr[0], 1, n);
    vectors++;
    if (n !== 0 || rd_buf[0] !== mmem[exp_wr[0]]) begin
      miscompares++;
      $display("FAIL after_rst_xfer got=%h nacks=%0d exp=%h nacks=0", rd_buf[0], n, mmem[exp_wr[0]]);
    end
  endtask

  task automatic test_random;
    int addr, cnt, n, ra;
    for (int it = 0; it < 8; it++) begin
      addr = $urandom_range(0, DEPTH - 1);
      cnt  = $urandom_range(1, 4);
      tx_data.delete();
      for (int i = 0; i < cnt; i++) tx_data.push_back(8'($urandom));
      wr_log.delete();
      xfer_write(addr, 1'b1, n);
      model_write(addr);
      wait_q;
      vectors++;
      if (n !== 0 || !logs_match()) begin
        miscompares++;
        $display("FAIL rand_write[%0d] nacks=%0d pulses=%0d exp nacks=0 pulses=%0d addr=%h", it, n, wr_log.size(), exp_wr.size(), addr);
      end
      xfer_read(addr, cnt, n);
      vectors++; if (n !== 0) begin miscompares++; $display("FAIL rand_read_acks[%0d] nacks=%0d exp=0", it, n); end
      for (int i = 0; i < cnt; i++) begin
        ra = (addr + i) % DEPTH;
        if (mval[ra]) begin
          vectors++;
          if (rd_buf[i] !== mmem[ra]) begin
            miscompares++;
            $display("FAIL rand_read[%0d] addr=%h got=%h exp=%h", it, ra, rd_buf[i], mmem[ra]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_random_read;
    test_page_wrap;
    test_wrong_addr;
    test_partial;
    test_reset_mid_read;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
